mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Sequential multiply/divide controller for the EXE stage of the RV32 core.
- Accepts an M-extension op from EXE and runs an iterative shift-add multiply or restoring divide over one shared datapath.
- Raises `mdu_hazard`, which drives the hazard unit's `exe_hazard` input, until the result is ready.
- Holds the result while downstream stages are stalled, and abandons the op when a flush occurs.

Parameters:
- XLEN, 32, operand/result width (power of two, ≥8).
- CNTW, $clog2(XLEN)+1, iteration counter width (derived, not overridable).

Ports:
- clk, input, 1, core clock.
- rstn, input, 1, reset: asynchronous, active-low.
- req, input, 1, valid M-extension op present in EXE.
- op, input, 3, funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1, input, XLEN, rs1 value.
- src2, input, XLEN, rs2 value.
- stall_in, input, 1, EXE held by a higher-priority stall (dpu_hazard path).
- flush_in, input, 1, EXE flush (exe_flush_force or exe_flush from the hazard unit).
- mdu_hazard, output, 1, request to stall IF/ID/EXE; wired to `exe_hazard`.
- res_valid, output, 1, `res` is valid this cycle.
- res, output, XLEN, result.

Behaviour:
- Reset: state = IDLE; counter, operand registers and `res` = 0; `mdu_hazard` = 0; `res_valid` = 0.
- States: IDLE, CALC, DONE.
- Combinational outputs:
  - `mdu_hazard` = req & (state != DONE) & ~flush_in.
  - `res_valid` = (state == DONE).
- IDLE, on req & ~flush_in:
  - Latch op and operands.
  - Signed ops (MULH, MULHSU, DIV, REM) store absolute values and record the result sign:
    - MULH: sign1 ^ sign2.
    - MULHSU: sign1 only.
    - DIV: sign1 ^ sign2.
    - REM: sign1.
  - Special cases go to DONE next cycle (latency 1) with the following `res` values:
    - Divisor 0: DIV/DIVU → all ones; REM/REMU → src1.
    - DIV with src1 = 100…0 and src2 = all ones: `res` = 100…0.
    - REM with src1 = 100…0 and src2 = all ones: `res` = 0.
  - Otherwise load counter = XLEN and go to CALC.
- CALC: one iteration per cycle; counter decrements.
  - Multiply: 2·XLEN accumulator; add multiplicand when multiplier LSB = 1, then shift right.
  - Divide: restoring; shift remainder:quotient left 1, trial-subtract divisor, set quotient bit when no borrow.
  - When counter reaches 1, the final iteration writes `res` and the FSM goes to DONE.
  - Sign correction (two's-complement negate) is applied in the same write.
  - `res` selection:
    - MUL: low XLEN bits of the product.
    - MULH/MULHSU/MULHU: high XLEN bits of the product; signed variants negate the full 2·XLEN product before selecting.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Normal latency from acceptance to `res_valid` = XLEN+1 cycles (33 for RV32).
- DONE:
  - `mdu_hazard` = 0, so the instruction may advance.
  - Go to IDLE when ~stall_in | flush_in. While stall_in = 1, remain in DONE and hold `res`.
  - No back-to-back acceptance: a new op is accepted from IDLE only, so the earliest next acceptance is the cycle after leaving DONE.
- Flush in any state: next state = IDLE; the current op is abandoned; `res` is not updated. Flush has priority over req in the same cycle.
- req dropping in CALC without flush (should not occur): go to IDLE, no result.
- Operands are sampled only at acceptance; later changes on src1/src2/op are ignored until IDLE.
- Asynchronous reset mid-op: immediate return to reset values, no result produced.
- Counter never wraps: CALC always exits at count 1.

Decomposition:
- Shared package `cpu_pkg`:
  - typedef `mdu_op_t` (enum of the 8 funct3 codes).
  - typedef `mdu_state_t` (IDLE/CALC/DONE).
  - constant MDU_OPS_DIV = op[2].
- One sub-module: `mdu_dp`, the shared shift/add/subtract iteration datapath (accumulator, quotient/remainder registers).
- `mdu_seq` keeps the FSM, counter, special-case detection and sign correction.

Test Plan:
1. MUL, src1=7, src2=6 → `mdu_hazard` high for 33 cycles from acceptance, then `res_valid` = 1 with `res` = 42.
2. MULH, src1=0x80000000, src2=0x80000000 → `res` = 0x40000000. MULHSU, src1=0xFFFFFFFF, src2=2 → `res` = 0xFFFFFFFF.
3. DIV, src1=-7 (0xFFFFFFF9), src2=2 → `res` = 0xFFFFFFFD. REM on the same operands → `res` = 0xFFFFFFFF. REMU, 7, 2 → `res` = 1.
4. DIVU, src1=5, src2=0 → `res_valid` 1 cycle after acceptance with `res` = 0xFFFFFFFF. REM, src1=0x80000000, src2=0xFFFFFFFF → `res` = 0 with latency 1.
5. DIV in flight, pulse flush_in at CALC cycle 10 → state returns to IDLE, `mdu_hazard` falls in the flush cycle, `res_valid` never asserts. A new MUL 3×3 then yields `res` = 9.
6. MUL 5×5 reaches DONE while stall_in = 1 for 4 cycles → `res_valid` stays 1 with `res` = 25 held constant for all 4 cycles; FSM is in IDLE the cycle after stall_in drops.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the RV32 multiply/divide unit
package cpu_pkg;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   // funct3 bit that separates divide/remainder ops from multiply ops
   localparam int MDU_OPS_DIV = 2;

endpackage

// File: rtl/mdu_dp.sv
// mdu_dp: shared shift/add/subtract iteration datapath for mdu_seq
module mdu_dp #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load,
   input  logic              step,
   input  logic              div,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [2*XLEN-1:0] acc_nxt
);

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opb;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     diff;

   // one iteration: add-then-shift-right for multiply, shift-left/trial-subtract for divide
   always_comb begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      diff    = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
      acc_nxt = !div ? {sum, acc[XLEN-1:1]}
              : diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   end

   // accumulator holds {product_hi, multiplier} or {remainder, quotient}
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc <= '0;
         opb <= '0;
      end else if (load) begin
         acc <= {{XLEN{1'b0}}, a};
         opb <= b;
      end else if (step) begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV32M multiply/divide controller for the EXE stage
module mdu_seq
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            req,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            stall_in,
   input  logic            flush_in,
   output logic            mdu_hazard,
   output logic            res_valid,
   output logic [XLEN-1:0] res
);

   localparam int CNTW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_t        state;
   mdu_op_t           op_r;
   logic [CNTW-1:0]   cnt;
   logic              neg;
   logic              sgn1;
   logic              sgn2;
   logic              div_by0;
   logic              ovf;
   logic              special;
   logic              accept;
   logic              step;
   logic [XLEN-1:0]   a_abs;
   logic [XLEN-1:0]   b_abs;
   logic [XLEN-1:0]   spc_res;
   logic [XLEN-1:0]   dv;
   logic [XLEN-1:0]   fin;
   logic [2*XLEN-1:0] acc_nxt;
   logic [2*XLEN-1:0] prod;

   // operand conditioning and special-case detection at acceptance
   always_comb begin
      sgn1    = src1[XLEN-1] & (op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
      sgn2    = src2[XLEN-1] & (op inside {MDU_MULH, MDU_DIV, MDU_REM});
      a_abs   = sgn1 ? -src1 : src1;
      b_abs   = sgn2 ? -src2 : src2;
      div_by0 = op[MDU_OPS_DIV] & (src2 == '0);
      ovf     = (op == MDU_DIV || op == MDU_REM) & (src1 == MIN) & (&src2);
      special = div_by0 | ovf;
      spc_res = div_by0 ? (op[1] ? src1 : '1) : (op[1] ? '0 : MIN);
      accept  = (state == IDLE) & req & ~flush_in;
      step    = (state == CALC) & req & ~flush_in;
   end

   // final-iteration result selection with sign correction
   always_comb begin
      prod = neg ? -acc_nxt : acc_nxt;
      dv   = op_r[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
      fin  = op_r[MDU_OPS_DIV] ? (neg ? -dv : dv)
           : (op_r == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   assign mdu_hazard = req & (state != DONE) & ~flush_in;
   assign res_valid  = (state == DONE);

   mdu_dp #(.XLEN(XLEN)) u_dp (
      .clk     (clk),
      .rstn    (rstn),
      .load    (accept),
      .step    (step),
      .div     (op_r[MDU_OPS_DIV]),
      .a       (a_abs),
      .b       (b_abs),
      .acc_nxt (acc_nxt)
   );

   // control FSM: accept, iterate XLEN times, hold result until EXE moves on
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         op_r  <= MDU_MUL;
         cnt   <= '0;
         neg   <= 1'b0;
         res   <= '0;
      end else if (flush_in) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (req) begin
               op_r <= mdu_op_t'(op);
               neg  <= (op == MDU_REM) ? sgn1 : sgn1 ^ sgn2;
               if (special) begin
                  res   <= spc_res;
                  state <= DONE;
               end else begin
                  cnt   <= CNTW'(XLEN);
                  state <= CALC;
               end
            end
            CALC: if (!req) begin
               state <= IDLE;
            end else begin
               cnt <= cnt - 1'b1;
               if (cnt == CNTW'(1)) begin
                  res   <= fin;
                  state <= DONE;
               end
            end
            DONE: if (!stall_in) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: table, random and hand-written sequence checks for mdu_seq
module tb_mdu_seq;

   logic        clk;
   logic        rstn;
   logic        req;
   logic [2:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        stall_in;
   logic        flush_in;
   logic        mdu_hazard;
   logic        res_valid;
   logic [31:0] res;

   int n_chk;
   int n_fail;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [13];

   mdu_seq #(.XLEN(32)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req        (req),
      .op         (op),
      .src1       (src1),
      .src2       (src2),
      .stall_in   (stall_in),
      .flush_in   (flush_in),
      .mdu_hazard (mdu_hazard),
      .res_valid  (res_valid),
      .res        (res)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // RV32M semantics computed with wide integer arithmetic
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      p  = '0;
      case (o)
         3'd0, 3'd1: p = sa * sb;
         3'd2:       p = sa * ub;
         3'd3:       p = ua * ub;
         3'd4:       if (b == 0) p = '1; else p = sa / sb;
         3'd5:       if (b == 0) p = '1; else p = ua / ub;
         3'd6:       if (b == 0) p = ua; else p = sa % sb;
         default:    if (b == 0) p = ua; else p = ua % ub;
      endcase
      return (o[2] || o == 3'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(15));
         default: return $urandom;
      endcase
   endfunction

   // presents an op and waits for the result; returns with the unit in DONE and req still high
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit scr,
                         output logic [31:0] r, output int lat, output int hz);
      req  = 1'b1;
      op   = o;
      src1 = a;
      src2 = b;
      lat  = 0;
      hz   = 0;
      while (lat < 100) begin
         #1;
         if (mdu_hazard) hz++;
         @(posedge clk);
         #1;
         lat++;
         if (res_valid) break;
         if (scr) begin
            src1 = $urandom;
            src2 = $urandom;
            op   = 3'($urandom);
         end
      end
      r = res;
      chk("done_hazard", 64'(mdu_hazard), 64'd0);
   endtask

   task automatic retire();
      req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] r;
      int lat, hz, v;
      logic [2:0] o;
      logic [31:0] a, b;
      clk = 0; rstn = 0; req = 0; op = 0; src1 = 0; src2 = 0; stall_in = 0; flush_in = 0;
      n_chk = 0; n_fail = 0;
      vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'd42,         33};
      vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33};
      vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33};
      vecs[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
      vecs[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
      vecs[5]  = '{3'd7, 32'd7,          32'd2,          32'd1,          33};
      vecs[6]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[7]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      vecs[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      vecs[9]  = '{3'd6, 32'd9,          32'd0,          32'd9,          1};
      vecs[10] = '{3'd4, 32'd100,        32'd0,          32'hFFFF_FFFF,  1};
      vecs[11] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
      vecs[12] = '{3'd5, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};

      #3;
      chk("rst_hazard", 64'(mdu_hazard), 64'd0);
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_res", 64'(res), 64'd0);
      @(posedge clk);
      #1;
      rstn = 1;

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r, lat, hz);
         chk($sformatf("vec%0d_res", i), 64'(r), 64'(vecs[i].exp));
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("vec%0d_hazard_cycles", i), 64'(hz), 64'(vecs[i].lat));
         retire();
      end

      // asynchronous reset in the middle of an op
      req = 1; op = 3'd0; src1 = 5; src2 = 5;
      repeat (6) begin @(posedge clk); #1; end
      req = 0;
      #1 rstn = 0;
      #1;
      chk("arst_valid", 64'(res_valid), 64'd0);
      chk("arst_res", 64'(res), 64'd0);
      #1 rstn = 1;
      @(posedge clk);
      #1;

      // randomized ops, operands scrambled after acceptance
      for (int k = 0; k < 60; k++) begin
         o = 3'($urandom);
         a = pick();
         b = pick();
         run_op(o, a, b, 1'b1, r, lat, hz);
         chk($sformatf("rnd%0d_op%0d_%h_%h_res", k, o, a, b), 64'(r), 64'(model(o, a, b)));
         chk($sformatf("rnd%0d_lat", k), 64'(lat), 64'(model_lat(o, a, b)));
         retire();
      end

      // flush at CALC cycle 10, new MUL presented right after
      req = 1; op = 3'd4; src1 = 1000; src2 = 7;
      repeat (10) begin @(posedge clk); #1; end
      flush_in = 1;
      #1;
      chk("flush_hazard", 64'(mdu_hazard), 64'd0);
      @(posedge clk);
      #1;
      flush_in = 0;
      chk("flush_no_valid", 64'(res_valid), 64'd0);
      run_op(3'd0, 32'd3, 32'd3, 1'b0, r, lat, hz);
      chk("after_flush_res", 64'(r), 64'd9);
      chk("after_flush_lat", 64'(lat), 64'd33);
      retire();

      // flush wins over req in IDLE: op must not start until flush drops
      req = 1; op = 3'd0; src1 = 4; src2 = 4; flush_in = 1;
      #1;
      chk("idle_flush_hazard", 64'(mdu_hazard), 64'd0);
      @(posedge clk);
      #1;
      flush_in = 0;
      run_op(3'd0, 32'd4, 32'd4, 1'b0, r, lat, hz);
      chk("idle_flush_res", 64'(r), 64'd16);
      chk("idle_flush_lat", 64'(lat), 64'd33);
      retire();

      // result held in DONE while stalled
      stall_in = 1;
      run_op(3'd0, 32'd5, 32'd5, 1'b0, r, lat, hz);
      v = 0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stall%0d_valid", i), 64'(res_valid), 64'd1);
         chk($sformatf("stall%0d_res", i), 64'(res), 64'd25);
         if (i < 3) begin @(posedge clk); #1; end
      end
      stall_in = 0;
      req = 0;
      @(posedge clk);
      #1;
      chk("stall_release_idle", 64'(res_valid), 64'd0);
      chk("stall_release_hazard", 64'(mdu_hazard), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
